// File: rtl/serial_operand_loader_if.sv
// Bundle between the narrow framed input bus and the FPU operand stage.
interface serial_operand_loader_if #(
  parameter int DATA_W = 16,
  parameter int PIN_W  = 10,
  parameter int OP_W   = 4
);
  logic [PIN_W-1:0]  inp;
  logic [DATA_W-1:0] num1;
  logic [DATA_W-1:0] num2;
  logic [OP_W-1:0]   op;
  logic              start;
  logic              busy;
  logic              err;

  modport master (output inp, input num1, num2, op, start, busy, err);
  modport slave  (input inp, output num1, num2, op, start, busy, err);
endinterface

// File: rtl/serial_operand_loader.sv
// Framed serial loader: header(op) + BEATS chunks of A + BEATS chunks of B.
// Define SERIAL_OPERAND_LOADER_CHKSUM_EN to require a trailing XOR check beat.
module serial_operand_loader #(
  parameter int DATA_W = 16,
  parameter int PIN_W  = 10,
  parameter int OP_W   = 4
) (
  input logic                    clock,
  input logic                    reset,
  serial_operand_loader_if.slave bus
);
  localparam int CHUNK_W = PIN_W - 2;
  localparam int BEATS   = (DATA_W + CHUNK_W - 1) / CHUNK_W;
  localparam int SH_W    = BEATS * CHUNK_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B} state_t;
`endif

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SH_W-1:0]     pend_a, pend_b;
  logic [OP_W-1:0]     pend_op;
  logic [DATA_W-1:0]   num1_q, num2_q;
  logic [OP_W-1:0]     op_q;
  logic                start_q, busy_q, err_q;
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
  logic [CHUNK_W-1:0]  chk;
`endif

  logic                valid, sof, last;
  logic [CHUNK_W-1:0]  payload;
  logic [SH_W-1:0]     a_next, b_next;

  assign valid   = bus.inp[PIN_W-1];
  assign sof     = bus.inp[PIN_W-2];
  assign payload = bus.inp[CHUNK_W-1:0];
  assign last    = (cnt == CNT_W'(BEATS - 1));

  // LSB chunk first: each new chunk enters at the top and shifts down.
  always_comb begin
    a_next = pend_a;
    b_next = pend_b;
    if (BEATS > 1) begin
      a_next = {payload, pend_a[SH_W-1:CHUNK_W]};
      b_next = {payload, pend_b[SH_W-1:CHUNK_W]};
    end else begin
      a_next = SH_W'(payload);
      b_next = SH_W'(payload);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_a  <= '0;
      pend_b  <= '0;
      pend_op <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
      chk     <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      if (valid) begin
        if (sof) begin
          // A header always resyncs; outside IDLE it also kills the partial frame.
          err_q   <= (state != IDLE);
          pend_op <= payload[OP_W-1:0];
          pend_a  <= '0;
          pend_b  <= '0;
          cnt     <= '0;
          state   <= LOAD_A;
          busy_q  <= 1'b1;
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
          chk     <= payload;
`endif
        end else begin
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
          chk <= chk ^ payload;
`endif
          case (state)
            LOAD_A: begin
              pend_a <= a_next;
              cnt    <= last ? '0 : cnt + 1'b1;
              if (last) state <= LOAD_B;
            end
            LOAD_B: begin
              pend_b <= b_next;
              cnt    <= last ? '0 : cnt + 1'b1;
              if (last) begin
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
                state <= CHECK;
`else
                num1_q  <= pend_a[DATA_W-1:0];
                num2_q  <= b_next[DATA_W-1:0];
                op_q    <= pend_op;
                start_q <= 1'b1;
                state   <= IDLE;
                busy_q  <= 1'b0;
`endif
              end
            end
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
            CHECK: begin
              if (payload == chk) begin
                num1_q  <= pend_a[DATA_W-1:0];
                num2_q  <= pend_b[DATA_W-1:0];
                op_q    <= pend_op;
                start_q <= 1'b1;
              end else begin
                err_q   <= 1'b1;
              end
              state  <= IDLE;
              busy_q <= 1'b0;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.num1  = num1_q;
  assign bus.num2  = num2_q;
  assign bus.op    = op_q;
  assign bus.start = start_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_serial_operand_loader.sv
// Scoreboard bench: one input stream feeds a 16-bit and a 32-bit loader.
module tb_serial_operand_loader;
  localparam int CW = 8;
`ifdef SERIAL_OPERAND_LOADER_CHKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    bit          is_err;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [3:0]  op;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] inp_drv = '0;
  int         checks = 0;
  int         failures = 0;
  int         starts16 = 0;

  ev_t         expq0[$];
  ev_t         expq1[$];
  int unsigned fr[2][16];
  int          fl[2] = '{0, 0};
  logic [31:0] good_n1[2] = '{0, 0};
  logic [31:0] good_n2[2] = '{0, 0};
  logic [3:0]  good_op[2] = '{0, 0};

  always #5 clock = ~clock;

  serial_operand_loader_if #(.DATA_W(16), .PIN_W(10), .OP_W(4)) b16 ();
  serial_operand_loader_if #(.DATA_W(32), .PIN_W(10), .OP_W(4)) b32 ();
  assign b16.inp = inp_drv;
  assign b32.inp = inp_drv;

  serial_operand_loader #(.DATA_W(16), .PIN_W(10), .OP_W(4)) dut16 (
    .clock(clock), .reset(reset), .bus(b16));
  serial_operand_loader #(.DATA_W(32), .PIN_W(10), .OP_W(4)) dut32 (
    .clock(clock), .reset(reset), .bus(b32));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int dw_of(input int k);
    return (k == 0) ? 16 : 32;
  endfunction

  task automatic push_ev(input int k, input ev_t e);
    if (k == 0) expq0.push_back(e);
    else expq1.push_back(e);
  endtask

  // Frame-level reference: collect the beats of a frame, decode when complete.
  task automatic model_step(input int k, input logic [9:0] v);
    int nb, need;
    ev_t e;
    logic [63:0] a, b, mask;
    int unsigned x;
    if (!v[9]) return;
    nb   = (dw_of(k) + CW - 1) / CW;
    need = 1 + 2 * nb + CHK;
    e = '{is_err: 1'b1, n1: '0, n2: '0, op: '0};
    if (v[8]) begin
      if (fl[k] > 0) push_ev(k, e);
      fr[k][0] = 32'(v[7:0]);
      fl[k] = 1;
    end else if (fl[k] > 0) begin
      fr[k][fl[k]] = 32'(v[7:0]);
      fl[k]++;
      if (fl[k] == need) begin
        a = '0; b = '0; x = 0;
        for (int i = 0; i < nb; i++) begin
          a |= 64'(fr[k][1 + i]) << (i * CW);
          b |= 64'(fr[k][1 + nb + i]) << (i * CW);
        end
        for (int i = 0; i < 1 + 2 * nb; i++) x ^= fr[k][i];
        mask = (64'd1 << dw_of(k)) - 64'd1;
        if (CHK != 0 && x != fr[k][need - 1]) begin
          push_ev(k, e);
        end else begin
          good_n1[k] = 32'(a & mask);
          good_n2[k] = 32'(b & mask);
          good_op[k] = 4'(fr[k][0]);
          e = '{is_err: 1'b0, n1: good_n1[k], n2: good_n2[k], op: good_op[k]};
          push_ev(k, e);
        end
        fl[k] = 0;
      end
    end
  endtask

  task automatic mon(input int k, input logic st, input logic er, input logic bz,
                     input logic [31:0] n1, input logic [31:0] n2, input logic [3:0] o);
    ev_t e;
    int  qs;
    qs = (k == 0) ? expq0.size() : expq1.size();
    if (st && er) begin
      checks++; failures++;
      $display("FAIL start_err_overlap dut=%0d", k);
    end
    chk($sformatf("busy%0d", k), 64'(bz), 64'(fl[k] > 0));
    chk($sformatf("num1_%0d", k), 64'(n1), 64'(good_n1[k]));
    chk($sformatf("num2_%0d", k), 64'(n2), 64'(good_n2[k]));
    chk($sformatf("op_%0d", k), 64'(o), 64'(good_op[k]));
    if (qs == 0) begin
      chk($sformatf("stray_pulse%0d", k), {62'd0, st, er}, 64'd0);
    end else begin
      e = (k == 0) ? expq0.pop_front() : expq1.pop_front();
      chk($sformatf("pulse%0d", k), {62'd0, st, er}, e.is_err ? 64'd1 : 64'd2);
    end
  endtask

  always @(negedge clock) begin
    mon(0, b16.start, b16.err, b16.busy, 32'(b16.num1), 32'(b16.num2), b16.op);
    mon(1, b32.start, b32.err, b32.busy, b32.num1, b32.num2, b32.op);
    if (b16.start) starts16++;
  end

  task automatic beat(input logic [9:0] v);
    @(negedge clock);
    inp_drv = v;
    @(posedge clock);
    if (reset) begin
      model_step(0, v);
      model_step(1, v);
    end
  endtask

  task automatic send_frame(input logic [7:0] pl[$], input bit stall);
    foreach (pl[i]) begin
      beat(10'h200 | 10'(pl[i]) | ((i == 0) ? 10'h100 : 10'h000));
      if (stall && i != pl.size() - 1) beat(10'h000);
    end
  endtask

  function automatic logic [7:0] xor_all(input logic [7:0] pl[$]);
    logic [7:0] x = '0;
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  logic [7:0] fb[$];
  logic [7:0] fx[$];

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk("rst_num1", 64'(b16.num1), 64'd0);
    chk("rst_flags", {61'd0, b16.start, b16.busy, b16.err}, 64'd0);
    @(negedge clock);
    #2 reset = 1'b1;

    // Basic frame (explicit raw beats).
    fb = '{8'h03, 8'h00, 8'h3C, 8'h00, 8'h40};
    if (CHK != 0) fb.push_back(xor_all(fb));
    send_frame(fb, 1'b0);
    #1;
    chk("basic_num1", 64'(b16.num1), 64'h3C00);
    chk("basic_num2", 64'(b16.num2), 64'h4000);
    chk("basic_op", 64'(b16.op), 64'h3);
    chk("basic_start_busy", {62'd0, b16.start, b16.busy}, 64'd2);
    if (CHK != 0) chk("basic_chk_beat", 64'(fb[5]), 64'h7F);
    beat(10'h000);

    // Same frame with stalls between beats.
    starts16 = 0;
    send_frame(fb, 1'b1);
    beat(10'h000); beat(10'h000);
    chk("stall_start_once", 64'(starts16), 64'd1);
    chk("stall_num1", 64'(b16.num1), 64'h3C00);

    // Abort then restart with op 1.
    beat(10'h305);
    beat(10'h211);
    beat(10'h301);
    #1;
    chk("abort_err", 64'(b16.err), 64'd1);
    chk("abort_hold_op", 64'(b16.op), 64'h3);
    fx = '{8'h01, 8'h00, 8'h3C, 8'h00, 8'h40};
    beat(10'h200); beat(10'h23C); beat(10'h200); beat(10'h240);
    if (CHK != 0) beat(10'h200 | 10'(xor_all(fx)));
    #1;
    chk("abort_num1", 64'(b16.num1), 64'h3C00);
    chk("abort_op", 64'(b16.op), 64'h1);
    beat(10'h000);

    // Reset mid-frame.
    beat(10'h303);
    beat(10'h200);
    @(negedge clock);
    #2 reset = 1'b0;
    fl = '{0, 0};
    good_n1 = '{0, 0}; good_n2 = '{0, 0}; good_op = '{0, 0};
    expq0.delete(); expq1.delete();
    #1;
    chk("midrst_num", {32'(b16.num1), 28'd0, b16.op}, 64'd0);
    chk("midrst_flags", {61'd0, b16.start, b16.busy, b16.err}, 64'd0);
    @(negedge clock);
    #2 reset = 1'b1;
    beat(10'h23C);
    beat(10'h240);
    #1;
    chk("stray_ignored", {61'd0, b16.start, b16.busy, b16.err}, 64'd0);

    // Checksum error keeps prior outputs.
    if (CHK != 0) begin
      send_frame(fb, 1'b0);
      beat(10'h303); beat(10'h200); beat(10'h23C); beat(10'h200); beat(10'h240); beat(10'h27E);
      #1;
      chk("cksum_err", {62'd0, b16.start, b16.err}, 64'd1);
      chk("cksum_hold", 64'(b16.num1), 64'h3C00);
      beat(10'h000);
    end

    // 32-bit instance: four chunks per operand.
    fb = '{8'h0A, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h02, 8'h03, 8'h04};
    if (CHK != 0) fb.push_back(xor_all(fb));
    send_frame(fb, 1'b0);
    #1;
    chk("w32_num1", 64'(b32.num1), 64'hDEADBEEF);
    chk("w32_num2", 64'(b32.num2), 64'h04030201);
    chk("w32_op", 64'(b32.op), 64'hA);
    beat(10'h000);

    // Randomized frames: mixed lengths, stalls, aborts, bad checksums.
    for (int n = 0; n < 300; n++) begin
      int nb, len;
      nb = ($urandom_range(1) != 0) ? 4 : 2;
      fb = {};
      fb.push_back(8'($urandom));
      for (int i = 0; i < 2 * nb; i++) fb.push_back(8'($urandom));
      if (CHK != 0) fb.push_back(xor_all(fb) ^ (($urandom_range(3) == 0) ? 8'($urandom) : 8'h00));
      len = ($urandom_range(7) == 0) ? int'($urandom_range(fb.size() - 1, 1)) : fb.size();
      for (int i = 0; i < len; i++) begin
        beat(10'h200 | 10'(fb[i]) | ((i == 0) ? 10'h100 : 10'h000));
        while ($urandom_range(3) == 0) beat(10'($urandom) & 10'h1FF);
      end
      if ($urandom_range(5) == 0) beat(10'h200 | 10'($urandom_range(255)));
    end

    repeat (3) beat(10'h000);
    chk("drain_q16", 64'(expq0.size()), 64'd0);
    chk("drain_q32", 64'(expq1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
